// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl
//
// FIFO controller for an external 8 x 16 single-ported RAM (ram8) that has a
// combinational read. The controller keeps up to 8 words in the RAM plus one
// word in its registered output stage, so it holds up to 9 words in total.
//
// Because the RAM has a single port, a read and a write can never happen in
// the same cycle. Reads win, so that the output register is refilled as soon
// as it frees up. As a result, a continuously active producer and consumer
// move one word every two cycles.
//
// Ports
//   clk        rising-edge clock, shared with ram8
//   reset      synchronous, active-high
//   in_valid   producer offers in_data
//   in_data    write word (16 bits)
//   in_ready   in_data is accepted this cycle
//   out_valid  out_data holds a valid word
//   out_data   registered head-of-queue word (16 bits)
//   out_ready  consumer takes out_data this cycle
//   count      words held, RAM plus output register (0..9)
//   full       RAM holds 8 words
//   empty      count == 0
//   mem_addr   ram8 addr
//   mem_we     ram8 we
//   mem_wdata  ram8 data_in
//   mem_rdata  ram8 data_out (word at mem_addr, same cycle)

module ram8_fifo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty,
    output logic [2:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] mem_count;
    logic       rd_en;
    logic       wr_en;

    // A read is issued whenever the output register is free, or is being
    // emptied this cycle. Holding reads off during reset makes the reset
    // cycle always present in_ready = 1, with the address on wr_ptr. A write
    // accepted in that cycle still reaches the RAM, but the pointer reset
    // throws it away.
    always_comb begin
        rd_en     = !reset && (mem_count != 4'd0) && (!out_valid || out_ready);
        in_ready  = reset || ((mem_count != 4'd8) && !rd_en);
        wr_en     = in_valid && in_ready;
        mem_we    = wr_en;
        mem_addr  = rd_en ? rd_ptr : wr_ptr;
        mem_wdata = in_data;
    end

    always_comb begin
        count = mem_count + {3'b000, out_valid};
        full  = (mem_count == 4'd8);
        empty = (count == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            mem_count <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 3'd1;
            end

            if (rd_en) begin
                rd_ptr    <= rd_ptr + 3'd1;
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                // out_data keeps its last value, so only the flag drops.
                out_valid <= 1'b0;
            end

            // rd_en and wr_en are mutually exclusive by construction.
            if (wr_en) begin
                mem_count <= mem_count + 4'd1;
            end else if (rd_en) begin
                mem_count <= mem_count - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
module tb_ram8_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [2:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    ram8_fifo_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram8 model: synchronous write, combinational read
    logic [15:0] ram [8];
    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 16'hDEAD;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: RAM contents as a queue, plus an output-register image.
    // sb holds every accepted word not yet taken by the consumer.
    logic [15:0] m_mem [$];
    logic [15:0] sb [$];
    logic        m_ov;
    logic [15:0] m_od;
    logic [2:0]  m_wp;
    logic [2:0]  m_rp;

    // One clock cycle. It is entered and left at a falling edge.
    task automatic cyc(input logic iv, input logic [15:0] id, input logic ordy, input logic rst,
                       output logic acc, output logic p_ir, output logic p_we, output logic [2:0] p_addr);
        logic        m_rd;
        logic        m_ir;
        logic        m_wr;
        logic [2:0]  m_addr;
        logic [15:0] exp_w;
        int          c;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        reset     = rst;
        #1;
        m_rd   = !rst && (m_mem.size() != 0) && (!m_ov || ordy);
        m_ir   = rst || ((m_mem.size() != 8) && !m_rd);
        m_wr   = iv && m_ir;
        m_addr = m_rd ? m_rp : m_wp;
        p_ir   = in_ready;
        p_we   = mem_we;
        p_addr = mem_addr;
        chk("in_ready", in_ready, m_ir);
        chk("mem_we", mem_we, m_wr);
        chk("mem_addr", mem_addr, m_addr);
        if (m_wr) chk("mem_wdata", mem_wdata, id);
        if (!rst && m_ov && ordy) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                chk("out_data_order", out_data, exp_w);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_mem.delete();
            sb.delete();
            m_ov = 1'b0;
            m_od = 16'h0000;
            m_wp = 3'd0;
            m_rp = 3'd0;
        end else begin
            if (m_rd) begin
                m_od = m_mem.pop_front();
                m_ov = 1'b1;
                m_rp = m_rp + 3'd1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (m_wr) begin
                m_mem.push_back(id);
                sb.push_back(id);
                m_wp = m_wp + 3'd1;
            end
        end
        acc = m_wr && !rst;
        #1;
        c = m_mem.size() + int'(m_ov);
        chk("count", count, c);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("full", full, m_mem.size() == 8);
        chk("empty", empty, c == 0);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d, input logic ordy);
        logic       acc;
        logic       a;
        logic       b;
        logic [2:0] c;
        int         n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cyc(1'b1, d, ordy, 1'b0, acc, a, b, c);
            n++;
        end
        chk("push_accepted", acc, 1);
    endtask

    task automatic drain();
        logic       acc;
        logic       a;
        logic       b;
        logic [2:0] c;
        int         n;
        n = 0;
        while ((m_mem.size() != 0 || m_ov) && n < 30) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0, acc, a, b, c);
            n++;
        end
        chk("drain_empty", empty, 1);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        rst;
        logic        e_ir;
        logic        e_we;
        logic [2:0]  e_addr;
        logic [3:0]  e_cnt;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [15:0] id, logic ordy, logic rst,
                                logic ir, logic we, logic [2:0] addr, logic [3:0] cnt,
                                logic ov, logic [15:0] od, logic fl, logic em);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.rst = rst;
        v.e_ir = ir; v.e_we = we; v.e_addr = addr; v.e_cnt = cnt;
        v.e_ov = ov; v.e_od = od; v.e_full = fl; v.e_empty = em;
        return v;
    endfunction

    vec_t vecs [23];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic       p_ir;
        logic       p_we;
        logic [2:0] p_addr;
        int         acc_n;
        int         cycles;
        logic [15:0] nxt;

        //              iv  data      ordy rst | ir we addr | cnt ov od        full empty
        vecs[0]  = mk(1, 16'hAAAA, 0, 0,   1, 1, 3'd0,  4'd1, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 0,   0, 0, 3'd0,  4'd1, 1, 16'hAAAA, 0, 0);
        vecs[2]  = mk(1, 16'hBEEF, 0, 1,   1, 1, 3'd1,  4'd0, 0, 16'h0000, 0, 1);
        vecs[3]  = mk(1, 16'h0001, 0, 0,   1, 1, 3'd0,  4'd1, 0, 16'h0000, 0, 0);
        vecs[4]  = mk(1, 16'h0002, 0, 0,   0, 0, 3'd0,  4'd1, 1, 16'h0001, 0, 0);
        vecs[5]  = mk(1, 16'h0002, 0, 0,   1, 1, 3'd1,  4'd2, 1, 16'h0001, 0, 0);
        for (int i = 0; i < 7; i++)
            vecs[6+i] = mk(1, 16'(3+i), 0, 0, 1, 1, 3'(2+i), 4'(3+i), 1, 16'h0001, i == 6, 0);
        vecs[13] = mk(1, 16'h000A, 0, 0,   0, 0, 3'd1,  4'd9, 1, 16'h0001, 1, 0);
        for (int i = 0; i < 8; i++)
            vecs[14+i] = mk(0, 16'h0000, 1, 0, 0, 0, 3'(1+i), 4'(8-i), 1, 16'(2+i), 0, 0);
        vecs[22] = mk(0, 16'h0000, 1, 0,   1, 0, 3'd1,  4'd0, 0, 16'h0009, 0, 1);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        m_ov = 1'b0; m_od = 16'h0000; m_wp = 3'd0; m_rp = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Table: first push latency, reset with a discarded write, fill to 9,
        // rejected 10th push, drain in order with the pointers wrapping.
        for (int i = 0; i < 23; i++) begin
            cyc(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].rst, acc, p_ir, p_we, p_addr);
            chk($sformatf("vec%0d_in_ready", i), p_ir, vecs[i].e_ir);
            chk($sformatf("vec%0d_mem_we", i), p_we, vecs[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i), p_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
        end

        // Continuous push and pop of 20 words: one accept every two cycles.
        acc_n  = 0;
        cycles = 0;
        nxt    = 16'h1000;
        while (acc_n < 20 && cycles < 100) begin
            cyc(1'b1, nxt, 1'b1, 1'b0, acc, p_ir, p_we, p_addr);
            if (acc) begin
                acc_n++;
                nxt = nxt + 16'd1;
            end
            cycles++;
        end
        chk("thru_accepts", acc_n, 20);
        chk("thru_cycles", cycles, 39);
        drain();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0, 1'b0,
                acc, p_ir, p_we, p_addr);
        end
        drain();

        // Reset while holding 5 words
        for (int i = 0; i < 5; i++) push(16'(16'h0500 + i), 1'b0);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_out_data", out_data, 16'h0500);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, acc, p_ir, p_we, p_addr);
        chk("rst_in_ready", p_ir, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_out_valid", out_valid, 0);
        cyc(1'b1, 16'h5555, 1'b0, 1'b0, acc, p_ir, p_we, p_addr);
        chk("post_rst_we", p_we, 1);
        chk("post_rst_addr", p_addr, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
